// File: rtl/cpu_pkg.sv
// ---------------------------------------------------------------------------
// cpu_pkg
//   Types shared between the register-writeback queue and the register file.
//   - REG_SEL_W / REG_DATA_W : register select and register data widths.
//   - wpos_e                 : write-position encoding (full word, low byte,
//                              high byte, illegal).
//   - wb_entry_t             : one queued writeback {rd, data, pos}.
// ---------------------------------------------------------------------------
package cpu_pkg;

    localparam int REG_SEL_W  = 3;
    localparam int REG_DATA_W = 16;

    typedef enum logic [1:0] {
        WPOS_FULL = 2'd0,
        WPOS_LOW  = 2'd1,
        WPOS_HIGH = 2'd2,
        WPOS_BAD  = 2'd3
    } wpos_e;

    typedef struct packed {
        logic [REG_SEL_W-1:0]  rd;
        logic [REG_DATA_W-1:0] data;
        wpos_e                 pos;
    } wb_entry_t;

endpackage

// File: rtl/reg_writeback_if.sv
// ---------------------------------------------------------------------------
// reg_writeback_if
//   Result-source handshakes into the writeback queue.
//   ALU path : I_alu_valid, O_alu_ready, I_alu_rd, I_alu_data, I_alu_pos
//   Load path: I_mem_valid, O_mem_ready, I_mem_rd, I_mem_data, I_mem_pos
//   master : the producers (ALU / load unit)
//   slave  : the writeback queue
// ---------------------------------------------------------------------------
interface reg_writeback_if #(
    parameter int SEL_W  = 3,
    parameter int DATA_W = 16
);
    logic              I_alu_valid;
    logic              O_alu_ready;
    logic [SEL_W-1:0]  I_alu_rd;
    logic [DATA_W-1:0] I_alu_data;
    logic [1:0]        I_alu_pos;

    logic              I_mem_valid;
    logic              O_mem_ready;
    logic [SEL_W-1:0]  I_mem_rd;
    logic [DATA_W-1:0] I_mem_data;
    logic [1:0]        I_mem_pos;

    modport master (
        output I_alu_valid, I_alu_rd, I_alu_data, I_alu_pos,
        output I_mem_valid, I_mem_rd, I_mem_data, I_mem_pos,
        input  O_alu_ready, O_mem_ready
    );

    modport slave (
        input  I_alu_valid, I_alu_rd, I_alu_data, I_alu_pos,
        input  I_mem_valid, I_mem_rd, I_mem_data, I_mem_pos,
        output O_alu_ready, O_mem_ready
    );
endinterface

// File: rtl/wb_fifo.sv
// ---------------------------------------------------------------------------
// wb_fifo
//   In-order DEPTH x wb_entry_t synchronous FIFO.
//   clk_i   : clock (rising edge)
//   rst_ni  : asynchronous active-low reset, empties the FIFO
//   push_i  : write entry_i at tail (ignored when full)
//   entry_i : entry to write
//   pop_i   : drop head (ignored when empty)
//   head_o  : current head entry (valid when !empty_o)
//   full_o  : DEPTH entries held
//   empty_o : no entries held
//   count_o : number of entries held
//   DEPTH must be a power of two so the pointers wrap naturally.
// ---------------------------------------------------------------------------
module wb_fifo
    import cpu_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   push_i,
    input  wb_entry_t              entry_i,
    input  logic                   pop_i,
    output wb_entry_t              head_o,
    output logic                   full_o,
    output logic                   empty_o,
    output logic [$clog2(DEPTH):0] count_o
);

    localparam int AW = $clog2(DEPTH);

    wb_entry_t     mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          do_push, do_pop;

    assign full_o  = (count_q == (AW+1)'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign head_o  = mem_q[rd_ptr_q];

    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + (AW+1)'(1);
            2'b01:   count_d = count_q - (AW+1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is data only; the pointers decide what is valid.
    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= entry_i;
        end
    end

endmodule

// File: rtl/reg_writeback.sv
// ---------------------------------------------------------------------------
// reg_writeback
//   Writeback queue between the ALU / load result paths and the register-file
//   write port. Results are accepted over valid/ready (load has priority),
//   byte-lane shaped, buffered in order, and drained one per cycle while the
//   register file is enabled.
//
//   I_clk          : clock (rising edge)
//   I_reset_n      : asynchronous active-low reset
//   src            : reg_writeback_if.slave, ALU and load handshakes
//   I_rf_enable    : drain allowed when 1
//   O_rD_select    : register-file write select
//   O_rD_in        : register-file write data
//   O_rD_write     : one-cycle write strobe
//   O_rD_write_pos : register-file write position
//   O_count        : entries currently queued
//   O_pos_err      : one-cycle pulse when an illegal-pos entry is discarded
//   O_pending      : per-register pending-write mask
//
//   Optional feature macro: WB_PENDING_EN. When defined, O_pending is driven
//   from per-register counters of queued writes plus the write on the port
//   this cycle; when undefined, O_pending is tied to zero.
//
//   SEL_W / DATA_W must match cpu_pkg::REG_SEL_W / REG_DATA_W (entry type).
// ---------------------------------------------------------------------------
module reg_writeback
    import cpu_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int DATA_W = REG_DATA_W,
    parameter int SEL_W  = REG_SEL_W
) (
    input  logic                   I_clk,
    input  logic                   I_reset_n,
    reg_writeback_if.slave         src,
    input  logic                   I_rf_enable,
    output logic [SEL_W-1:0]       O_rD_select,
    output logic [DATA_W-1:0]      O_rD_in,
    output logic                   O_rD_write,
    output logic [1:0]             O_rD_write_pos,
    output logic [$clog2(DEPTH):0] O_count,
    output logic                   O_pos_err,
    output logic [2**SEL_W-1:0]    O_pending
);

    // Byte writes arrive in data[7:0]; the high-byte case moves it up a lane
    // and the unused lane is forced to zero.
    function automatic logic [DATA_W-1:0] shape_data(input logic [DATA_W-1:0] d,
                                                     input wpos_e             pos);
        logic [DATA_W-1:0] r;
        case (pos)
            WPOS_LOW:  r = DATA_W'(d[7:0]);
            WPOS_HIGH: r = DATA_W'(d[7:0]) << 8;
            default:   r = d;
        endcase
        return r;
    endfunction

    wb_entry_t push_entry;
    wb_entry_t head;
    logic      full, empty;
    logic      mem_take, alu_take, push, pop;

    logic [SEL_W-1:0]  sel_q, sel_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [1:0]        wpos_q, wpos_d;
    logic              write_q, write_d;
    logic              err_q, err_d;

    // Readiness looks only at the pre-pop fill level, so a full queue never
    // accepts even if it drains on the same edge.
    assign src.O_mem_ready = I_reset_n & ~full;
    assign src.O_alu_ready = I_reset_n & ~full & ~src.I_mem_valid;

    assign mem_take = src.I_mem_valid & src.O_mem_ready;
    assign alu_take = src.I_alu_valid & src.O_alu_ready;
    assign push     = mem_take | alu_take;
    assign pop      = ~empty & I_rf_enable;

    always_comb begin
        push_entry = '0;
        if (mem_take) begin
            push_entry.rd   = src.I_mem_rd;
            push_entry.pos  = wpos_e'(src.I_mem_pos);
            push_entry.data = shape_data(src.I_mem_data, wpos_e'(src.I_mem_pos));
        end else if (alu_take) begin
            push_entry.rd   = src.I_alu_rd;
            push_entry.pos  = wpos_e'(src.I_alu_pos);
            push_entry.data = shape_data(src.I_alu_data, wpos_e'(src.I_alu_pos));
        end
    end

    wb_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i   (I_clk),
        .rst_ni  (I_reset_n),
        .push_i  (push),
        .entry_i (push_entry),
        .pop_i   (pop),
        .head_o  (head),
        .full_o  (full),
        .empty_o (empty),
        .count_o (O_count)
    );

    // Output stage: a popped head becomes a one-cycle strobe. Illegal-pos
    // entries raise the error pulse instead and leave select/data/pos alone.
    always_comb begin
        write_d = 1'b0;
        err_d   = 1'b0;
        sel_d   = sel_q;
        data_d  = data_q;
        wpos_d  = wpos_q;
        if (pop) begin
            if (head.pos == WPOS_BAD) begin
                err_d = 1'b1;
            end else begin
                write_d = 1'b1;
                sel_d   = head.rd;
                data_d  = head.data;
                wpos_d  = head.pos;
            end
        end
    end

    always_ff @(posedge I_clk or negedge I_reset_n) begin
        if (!I_reset_n) begin
            write_q <= 1'b0;
            err_q   <= 1'b0;
            sel_q   <= '0;
            data_q  <= '0;
            wpos_q  <= '0;
        end else begin
            write_q <= write_d;
            err_q   <= err_d;
            sel_q   <= sel_d;
            data_q  <= data_d;
            wpos_q  <= wpos_d;
        end
    end

    assign O_rD_write     = write_q;
    assign O_pos_err      = err_q;
    assign O_rD_select    = sel_q;
    assign O_rD_in        = data_q;
    assign O_rD_write_pos = wpos_q;

`ifdef WB_PENDING_EN
    // One counter per register of legal writes still in the queue; a counter
    // can never exceed DEPTH, so it shares the count width.
    localparam int CW = $clog2(DEPTH) + 1;

    logic [CW-1:0] pend_cnt_q [2**SEL_W];
    logic [CW-1:0] pend_cnt_d [2**SEL_W];

    always_comb begin
        for (int i = 0; i < 2**SEL_W; i++) begin
            pend_cnt_d[i] = pend_cnt_q[i];
            if (push && push_entry.pos != WPOS_BAD && push_entry.rd == SEL_W'(i)) begin
                pend_cnt_d[i] = pend_cnt_d[i] + CW'(1);
            end
            if (pop && head.pos != WPOS_BAD && head.rd == SEL_W'(i)) begin
                pend_cnt_d[i] = pend_cnt_d[i] - CW'(1);
            end
        end
    end

    always_ff @(posedge I_clk or negedge I_reset_n) begin
        if (!I_reset_n) begin
            for (int i = 0; i < 2**SEL_W; i++) begin
                pend_cnt_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 2**SEL_W; i++) begin
                pend_cnt_q[i] <= pend_cnt_d[i];
            end
        end
    end

    // The write on the port this cycle has not reached the register file
    // yet, so its target still counts as pending.
    always_comb begin
        O_pending = '0;
        for (int i = 0; i < 2**SEL_W; i++) begin
            O_pending[i] = (pend_cnt_q[i] != '0) | (write_q & (sel_q == SEL_W'(i)));
        end
    end
`else
    assign O_pending = '0;
`endif

endmodule

// File: tb/tb_reg_writeback.sv
module tb_reg_writeback;
    import cpu_pkg::*;

    typedef struct packed {
        logic [2:0]  rd;
        logic [15:0] data;
        logic [1:0]  pos;
    } wr_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        rf_en;
    logic [2:0]  O_rD_select;
    logic [15:0] O_rD_in;
    logic        O_rD_write;
    logic [1:0]  O_rD_write_pos;
    logic [2:0]  O_count;
    logic        O_pos_err;
    logic [7:0]  O_pending;

    int  vectors = 0;
    int  errors  = 0;
    bit  pend_en;
    wr_t exp_q[$];
    wr_t obs_q[$];

    always #5 clk = ~clk;

    reg_writeback_if ifc ();

    reg_writeback dut (
        .I_clk          (clk),
        .I_reset_n      (rst_n),
        .src            (ifc),
        .I_rf_enable    (rf_en),
        .O_rD_select    (O_rD_select),
        .O_rD_in        (O_rD_in),
        .O_rD_write     (O_rD_write),
        .O_rD_write_pos (O_rD_write_pos),
        .O_count        (O_count),
        .O_pos_err      (O_pos_err),
        .O_pending      (O_pending)
    );

    // Independent model of what the register-file port should show.
    function automatic wr_t model(input logic [2:0] rd, input logic [15:0] d, input logic [1:0] pos);
        wr_t r;
        r.rd  = rd;
        r.pos = pos;
        case (pos)
            2'd0:    r.data = d;
            2'd1:    r.data = {8'h00, d[7:0]};
            2'd2:    r.data = {d[7:0], 8'h00};
            default: r = '{rd: 3'd0, data: 16'd0, pos: 2'd3};
        endcase
        return r;
    endfunction

    // Advance one cycle and record what the write port produced.
    task automatic tick();
        @(posedge clk);
        #1;
        if (O_rD_write) obs_q.push_back(wr_t'{O_rD_select, O_rD_in, O_rD_write_pos});
        if (O_pos_err) obs_q.push_back(wr_t'{3'd0, 16'd0, 2'd3});
    endtask

    task automatic idle_inputs();
        ifc.I_alu_valid = 1'b0;
        ifc.I_mem_valid = 1'b0;
    endtask

    task automatic drive_alu(input logic [2:0] rd, input logic [15:0] d, input logic [1:0] pos);
        ifc.I_alu_valid = 1'b1;
        ifc.I_alu_rd    = rd;
        ifc.I_alu_data  = d;
        ifc.I_alu_pos   = pos;
    endtask

    task automatic drive_mem(input logic [2:0] rd, input logic [15:0] d, input logic [1:0] pos);
        ifc.I_mem_valid = 1'b1;
        ifc.I_mem_rd    = rd;
        ifc.I_mem_data  = d;
        ifc.I_mem_pos   = pos;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        rf_en = 1'b1;
        drive_alu(3'd1, 16'h1111, 2'd0);
        drive_mem(3'd2, 16'h2222, 2'd0);
        repeat (2) @(posedge clk);
        #1;
        vectors++;
        if ({ifc.O_alu_ready, ifc.O_mem_ready} !== 2'b00) begin
            errors++;
            $display("FAIL reset_ready: got %b want 00", {ifc.O_alu_ready, ifc.O_mem_ready});
        end
        vectors++;
        if ({O_rD_write, O_pos_err, O_count, O_rD_select, O_rD_in, O_rD_write_pos, O_pending} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: write=%b err=%b cnt=%0d sel=%0d in=%h pos=%0d pend=%h want all 0",
                     O_rD_write, O_pos_err, O_count, O_rD_select, O_rD_in, O_rD_write_pos, O_pending);
        end
        idle_inputs();
        rst_n = 1'b1;
        tick();
        obs_q.delete();
    endtask

    task automatic test_single_write();
        rf_en = 1'b1;
        drive_alu(3'd3, 16'hBEEF, 2'd0);
        #1;
        vectors++;
        if (ifc.O_alu_ready !== 1'b1) begin
            errors++;
            $display("FAIL single_ready: got %b want 1", ifc.O_alu_ready);
        end
        exp_q.push_back(model(3'd3, 16'hBEEF, 2'd0));
        tick();
        idle_inputs();
        vectors++;
        if ({O_rD_write, O_count} !== {1'b0, 3'd1}) begin
            errors++;
            $display("FAIL single_queued: write=%b cnt=%0d want write=0 cnt=1", O_rD_write, O_count);
        end
        tick();
        vectors++;
        if ({O_rD_write, O_rD_select, O_rD_in, O_rD_write_pos} !== {1'b1, 3'd3, 16'hBEEF, 2'd0}) begin
            errors++;
            $display("FAIL single_strobe: write=%b sel=%0d in=%h pos=%0d want 1/3/beef/0",
                     O_rD_write, O_rD_select, O_rD_in, O_rD_write_pos);
        end
        tick();
        vectors++;
        if ({O_rD_write, O_rD_select, O_rD_in} !== {1'b0, 3'd3, 16'hBEEF}) begin
            errors++;
            $display("FAIL single_hold: write=%b sel=%0d in=%h want 0/3/beef", O_rD_write, O_rD_select, O_rD_in);
        end
        for (int k = 0; k < 20 && obs_q.size() < exp_q.size(); k++) tick();
        repeat (2) tick();
        vectors++;
        if (obs_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL single_nwrites: got %0d want %0d", obs_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            wr_t e, o;
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            vectors++;
            if (o !== e) begin
                errors++;
                $display("FAIL single_write: got rd=%0d d=%h pos=%0d want rd=%0d d=%h pos=%0d", o.rd, o.data, o.pos, e.rd, e.data, e.pos);
            end
        end
        exp_q.delete();
        obs_q.delete();
    endtask

    task automatic test_priority();
        rf_en = 1'b1;
        drive_mem(3'd1, 16'h00AA, 2'd2);
        drive_alu(3'd2, 16'h1234, 2'd0);
        #1;
        vectors++;
        if ({ifc.O_mem_ready, ifc.O_alu_ready} !== 2'b10) begin
            errors++;
            $display("FAIL prio_ready: mem/alu got %b want 10", {ifc.O_mem_ready, ifc.O_alu_ready});
        end
        exp_q.push_back(model(3'd1, 16'h00AA, 2'd2));
        tick();
        ifc.I_mem_valid = 1'b0;
        #1;
        vectors++;
        if (ifc.O_alu_ready !== 1'b1) begin
            errors++;
            $display("FAIL prio_alu_ready: got %b want 1", ifc.O_alu_ready);
        end
        exp_q.push_back(model(3'd2, 16'h1234, 2'd0));
        tick();
        idle_inputs();
        for (int k = 0; k < 20 && obs_q.size() < exp_q.size(); k++) tick();
        repeat (2) tick();
        vectors++;
        if (obs_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL prio_nwrites: got %0d want %0d", obs_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            wr_t e, o;
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            vectors++;
            if (o !== e) begin
                errors++;
                $display("FAIL prio_write: got rd=%0d d=%h pos=%0d want rd=%0d d=%h pos=%0d", o.rd, o.data, o.pos, e.rd, e.data, e.pos);
            end
        end
        exp_q.delete();
        obs_q.delete();
    endtask

    task automatic test_disabled_fill();
        logic [15:0] d;
        rf_en = 1'b0;
        for (int i = 0; i < 4; i++) begin
            d = 16'($urandom);
            drive_alu(3'(i + 4), d, 2'(i % 3));
            exp_q.push_back(model(3'(i + 4), d, 2'(i % 3)));
            tick();
        end
        idle_inputs();
        vectors++;
        if (O_count !== 3'd4) begin
            errors++;
            $display("FAIL fill_count: got %0d want 4", O_count);
        end
        ifc.I_alu_valid = 1'b1;
        ifc.I_mem_valid = 1'b1;
        #1;
        vectors++;
        if ({ifc.O_mem_ready, ifc.O_alu_ready} !== 2'b00) begin
            errors++;
            $display("FAIL fill_full_ready: got %b want 00", {ifc.O_mem_ready, ifc.O_alu_ready});
        end
        idle_inputs();
        repeat (2) tick();
        vectors++;
        if (obs_q.size() != 0 || O_count !== 3'd4) begin
            errors++;
            $display("FAIL fill_hold: writes=%0d cnt=%0d want 0 and 4", obs_q.size(), O_count);
        end
        rf_en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            vectors++;
            if (O_rD_write !== 1'b1) begin
                errors++;
                $display("FAIL fill_consecutive[%0d]: write=%b want 1", i, O_rD_write);
            end
        end
        repeat (2) tick();
        vectors++;
        if (obs_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL fill_nwrites: got %0d want %0d", obs_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            wr_t e, o;
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            vectors++;
            if (o !== e) begin
                errors++;
                $display("FAIL fill_write: got rd=%0d d=%h pos=%0d want rd=%0d d=%h pos=%0d", o.rd, o.data, o.pos, e.rd, e.data, e.pos);
            end
        end
        exp_q.delete();
        obs_q.delete();
    endtask

    task automatic test_pos_err();
        rf_en = 1'b1;
        drive_alu(3'd4, 16'h5A5A, 2'd0);
        exp_q.push_back(model(3'd4, 16'h5A5A, 2'd0));
        tick();
        ifc.I_alu_valid = 1'b0;
        drive_mem(3'd5, 16'h7777, 2'd3);
        exp_q.push_back(model(3'd5, 16'h7777, 2'd3));
        tick();
        vectors++;
        if ({O_rD_write, O_rD_select, O_pending[5]} !== {1'b1, 3'd4, 1'b0}) begin
            errors++;
            $display("FAIL poserr_first: write=%b sel=%0d pend5=%b want 1/4/0", O_rD_write, O_rD_select, O_pending[5]);
        end
        ifc.I_mem_valid = 1'b0;
        drive_alu(3'd6, 16'h12C3, 2'd1);
        exp_q.push_back(model(3'd6, 16'h12C3, 2'd1));
        tick();
        idle_inputs();
        vectors++;
        if ({O_pos_err, O_rD_write, O_rD_select, O_rD_in} !== {1'b1, 1'b0, 3'd4, 16'h5A5A}) begin
            errors++;
            $display("FAIL poserr_slot: err=%b write=%b sel=%0d in=%h want 1/0/4/5a5a", O_pos_err, O_rD_write, O_rD_select, O_rD_in);
        end
        for (int k = 0; k < 4; k++) begin
            tick();
            vectors++;
            if (O_pending[5] !== 1'b0 || (O_pos_err & O_rD_write) !== 1'b0) begin
                errors++;
                $display("FAIL poserr_pend5: pend5=%b err=%b write=%b want pend5=0, not both", O_pending[5], O_pos_err, O_rD_write);
            end
        end
        vectors++;
        if (obs_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL poserr_nwrites: got %0d want %0d", obs_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            wr_t e, o;
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            vectors++;
            if (o !== e) begin
                errors++;
                $display("FAIL poserr_write: got rd=%0d d=%h pos=%0d want rd=%0d d=%h pos=%0d", o.rd, o.data, o.pos, e.rd, e.data, e.pos);
            end
        end
        exp_q.delete();
        obs_q.delete();
    endtask

    task automatic test_reset_mid_drain();
        rf_en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive_alu(3'(i + 1), 16'(16'hC000 + i), 2'd0);
            if (i == 0) exp_q.push_back(model(3'd1, 16'hC000, 2'd0));
            tick();
        end
        idle_inputs();
        vectors++;
        if (O_count !== 3'd3) begin
            errors++;
            $display("FAIL rstmid_count: got %0d want 3", O_count);
        end
        rf_en = 1'b1;
        tick();
        vectors++;
        if ({O_rD_write, O_rD_select} !== {1'b1, 3'd1}) begin
            errors++;
            $display("FAIL rstmid_first: write=%b sel=%0d want 1/1", O_rD_write, O_rD_select);
        end
        rst_n = 1'b0;
        #1;
        vectors++;
        if ({O_rD_write, O_count, O_pending, O_pos_err} !== '0) begin
            errors++;
            $display("FAIL rstmid_async: write=%b cnt=%0d pend=%h err=%b want all 0", O_rD_write, O_count, O_pending, O_pos_err);
        end
        repeat (2) tick();
        rst_n = 1'b1;
        for (int k = 0; k < 20 && obs_q.size() < exp_q.size(); k++) tick();
        repeat (3) tick();
        vectors++;
        if (obs_q.size() != exp_q.size() || O_count !== 3'd0) begin
            errors++;
            $display("FAIL rstmid_nwrites: got %0d cnt=%0d want %0d cnt=0", obs_q.size(), O_count, exp_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            wr_t e, o;
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            vectors++;
            if (o !== e) begin
                errors++;
                $display("FAIL rstmid_write: got rd=%0d d=%h pos=%0d want rd=%0d d=%h pos=%0d", o.rd, o.data, o.pos, e.rd, e.data, e.pos);
            end
        end
        exp_q.delete();
        obs_q.delete();
    endtask

    task automatic test_pending();
        bit         pat [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
        logic [7:0] want;
        rf_en = 1'b1;
        for (int k = 0; k < 4; k++) begin
            if (k == 0) begin
                drive_alu(3'd7, 16'hA1A1, 2'd0);
                exp_q.push_back(model(3'd7, 16'hA1A1, 2'd0));
            end else if (k == 1) begin
                drive_alu(3'd7, 16'h00B2, 2'd2);
                exp_q.push_back(model(3'd7, 16'h00B2, 2'd2));
            end else begin
                idle_inputs();
            end
            tick();
            want = (pend_en && pat[k]) ? 8'h80 : 8'h00;
            vectors++;
            if (O_pending !== want) begin
                errors++;
                $display("FAIL pending[%0d]: got %h want %h", k, O_pending, want);
            end
        end
        idle_inputs();
        repeat (2) tick();
        vectors++;
        if (obs_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL pending_nwrites: got %0d want %0d", obs_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            wr_t e, o;
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            vectors++;
            if (o !== e) begin
                errors++;
                $display("FAIL pending_write: got rd=%0d d=%h pos=%0d want rd=%0d d=%h pos=%0d", o.rd, o.data, o.pos, e.rd, e.data, e.pos);
            end
        end
        exp_q.delete();
        obs_q.delete();
    endtask

    task automatic test_back_to_back();
        int          mcnt = 0;
        bit          mv, av, pushed;
        logic [2:0]  rd;
        logic [15:0] d;
        logic [1:0]  pos;
        for (int c = 0; c < 40; c++) begin
            mv    = ($urandom_range(0, 2) == 0);
            av    = ($urandom_range(0, 1) == 1);
            rf_en = ($urandom_range(0, 3) != 0);
            rd    = 3'($urandom);
            d     = 16'($urandom);
            pos   = 2'($urandom);
            idle_inputs();
            if (mv) drive_mem(rd, d, pos);
            if (av) drive_alu(3'(rd + 3'd1), ~d, 2'(pos + 2'd1));
            #1;
            vectors++;
            if ({ifc.O_mem_ready, ifc.O_alu_ready} !== {mcnt < 4, (mcnt < 4) && !mv}) begin
                errors++;
                $display("FAIL b2b_ready[%0d]: got %b want %b", c, {ifc.O_mem_ready, ifc.O_alu_ready}, {mcnt < 4, (mcnt < 4) && !mv});
            end
            pushed = 1'b0;
            if (mv && mcnt < 4) begin
                exp_q.push_back(model(rd, d, pos));
                pushed = 1'b1;
            end else if (av && mcnt < 4) begin
                exp_q.push_back(model(3'(rd + 3'd1), ~d, 2'(pos + 2'd1)));
                pushed = 1'b1;
            end
            mcnt = mcnt + int'(pushed) - int'(mcnt > 0 && rf_en);
            tick();
            vectors++;
            if (O_count !== 3'(mcnt)) begin
                errors++;
                $display("FAIL b2b_count[%0d]: got %0d want %0d", c, O_count, mcnt);
            end
        end
        idle_inputs();
        rf_en = 1'b1;
        for (int k = 0; k < 20 && obs_q.size() < exp_q.size(); k++) tick();
        repeat (2) tick();
        vectors++;
        if (obs_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL b2b_nwrites: got %0d want %0d", obs_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            wr_t e, o;
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            vectors++;
            if (o !== e) begin
                errors++;
                $display("FAIL b2b_write: got rd=%0d d=%h pos=%0d want rd=%0d d=%h pos=%0d", o.rd, o.data, o.pos, e.rd, e.data, e.pos);
            end
        end
        exp_q.delete();
        obs_q.delete();
    endtask

    initial begin
`ifdef WB_PENDING_EN
        pend_en = 1'b1;
`else
        pend_en = 1'b0;
`endif
        ifc.I_alu_valid = 1'b0;
        ifc.I_alu_rd    = '0;
        ifc.I_alu_data  = '0;
        ifc.I_alu_pos   = '0;
        ifc.I_mem_valid = 1'b0;
        ifc.I_mem_rd    = '0;
        ifc.I_mem_data  = '0;
        ifc.I_mem_pos   = '0;
        rf_en           = 1'b0;
        rst_n           = 1'b0;

        test_reset();
        test_single_write();
        test_priority();
        test_disabled_fill();
        test_pos_err();
        test_reset_mid_drain();
        test_pending();
        test_back_to_back();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
